ram8_bank: RTL

Eight-word, 16-bit Hack register bank, the storage stage directly upstream of the 8-way 16-bit output multiplexer in the RAM hierarchy. Holds eight Register16 words, decodes writes by address, and presents the addressed word on `out`. Adds a per-word valid bitmap and a sequential clear sweep, so RAM64 and the test harness can scrub a bank without issuing eight explicit writes.

---
 rtl/hack_pkg.sv | 15 +
 rtl/mux8way16.sv | 25 ++
 rtl/register16.sv | 20 ++
 rtl/ram8_bank.sv | 97 +++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack RAM-hierarchy types: word width, bank depth and the bank sweep FSM encoding.
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } ram8_state_t;

endpackage

// File: rtl/mux8way16.sv
// Hack Mux8Way16: selects one of eight 16-bit words by a 3-bit select.
module mux8way16
  import hack_pkg::*;
(
  input  word_t             data [DEPTH],
  input  logic [ADDR_W-1:0] sel,
  output word_t             out
);

  always_comb begin
    out = '0;
    case (sel)
      3'd0:    out = data[0];
      3'd1:    out = data[1];
      3'd2:    out = data[2];
      3'd3:    out = data[3];
      3'd4:    out = data[4];
      3'd5:    out = data[5];
      3'd6:    out = data[6];
      3'd7:    out = data[7];
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/register16.sv
// Hack Register16: 16-bit storage word with load enable and synchronous reset.
module register16
  import hack_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t in,
  output word_t out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/ram8_bank.sv
// Eight-word Hack register bank with per-word valid bitmap and an 8-cycle clear sweep.
// Optional write-through read path enabled by defining RAM8_BANK_BYPASS_EN.
module ram8_bank
  import hack_pkg::*;
#(
  parameter int unsigned WORD_W = hack_pkg::WORD_W,
  parameter int unsigned DEPTH  = hack_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in,
  input  logic              load,
  input  logic [2:0]        address,
  input  logic              clear,
  output logic [WORD_W-1:0] out,
  output logic [DEPTH-1:0]  valid,
  output logic              busy
);

  ram8_state_t       state;
  ram8_state_t       state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  word_load;
  word_t             word_data;
  word_t             words [DEPTH];
  word_t             read_word;

  // State, sweep index, valid bitmap and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      valid <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      valid <= valid_next;
      busy  <= (state_next == SWEEP);
    end
  end

  // Write decode: clear beats load in IDLE; the sweep owns the write port while active
  always_comb begin
    state_next = state;
    idx_next   = idx;
    valid_next = valid;
    word_load  = '0;
    word_data  = in;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = SWEEP;
          idx_next   = '0;
        end else if (load) begin
          word_load[address]  = 1'b1;
          valid_next[address] = 1'b1;
        end
      end
      SWEEP: begin
        word_load[idx]  = 1'b1;
        word_data       = '0;
        valid_next[idx] = 1'b0;
        idx_next        = idx + ADDR_W'(1);
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register16 u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (word_load[i]),
      .in    (word_data),
      .out   (words[i])
    );
  end

  mux8way16 u_mux (
    .data (words),
    .sel  (address),
    .out  (read_word)
  );

`ifdef RAM8_BANK_BYPASS_EN
  assign out = (load && !busy) ? in : read_word;
`else
  assign out = read_word;
`endif

endmodule
